// File: rtl/tft_funcmod.sv
// Write-only driver for a 16-bit 8080-style TFT bus: turns one-hot write requests
// into CS/RS/WR strobes with parameterised setup, low and high times.
module tft_funcmod #(
    parameter int unsigned T_SETUP = 1,
    parameter int unsigned T_WRL   = 3,
    parameter int unsigned T_WRH   = 3
) (
    input  logic        CLOCK,
    input  logic        RESET,
    input  logic [2:0]  iCall,
    output logic        oDone,
    input  logic [7:0]  iAddr,
    input  logic [15:0] iData,
    output logic        TFT_RST,
    output logic        TFT_CS,
    output logic        TFT_RS,
    output logic        TFT_WR,
    output logic        TFT_RD,
    output logic [15:0] TFT_DB
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_WRLO,
        S_WRHI,
        S_DONE,
        S_REC
    } state_e;

    localparam logic [7:0] LD_SETUP = 8'(T_SETUP - 1);
    localparam logic [7:0] LD_WRL   = 8'(T_WRL - 1);
    localparam logic [7:0] LD_WRH   = 8'(T_WRH - 1);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        is_reg_q, is_reg_d;
    logic        phase_q, phase_d;
    logic [15:0] data_q, data_d;
    logic        done_q, done_d;
    logic        cs_q, cs_d;
    logic        rs_q, rs_d;
    logic        wr_q, wr_d;
    logic [15:0] db_q, db_d;
    logic        rst_q;

    // NOTE: every signal written here gets its hold value first, so no path can infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        is_reg_d = is_reg_q;
        phase_d  = phase_q;
        data_d   = data_q;
        done_d   = 1'b0;
        cs_d     = cs_q;
        rs_d     = rs_q;
        wr_d     = wr_q;
        db_d     = db_q;

        unique case (state_q)
            // REC samples like IDLE, so a caller re-asserting after REC loses no cycle.
            S_IDLE, S_REC: begin
                state_d = S_IDLE;
                if (iCall != 3'b000) begin
                    state_d  = S_SETUP;
                    cnt_d    = LD_SETUP;
                    data_d   = iData;
                    is_reg_d = iCall[2];
                    cs_d     = 1'b0;
                    wr_d     = 1'b1;
                    if (iCall[2] || iCall[1]) begin
                        phase_d = 1'b0;
                        rs_d    = 1'b0;
                        db_d    = {8'h00, iAddr};
                    end else begin
                        phase_d = 1'b1;
                        rs_d    = 1'b1;
                        db_d    = iData;
                    end
                end
            end

            S_SETUP: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WRLO;
                    cnt_d   = LD_WRL;
                    wr_d    = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_WRLO: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_WRHI;
                    cnt_d   = LD_WRH;
                    wr_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_WRHI: begin
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (is_reg_q && !phase_q) begin
                    // Command phase of a register write done: CS stays low into the data phase.
                    state_d = S_SETUP;
                    cnt_d   = LD_SETUP;
                    phase_d = 1'b1;
                    rs_d    = 1'b1;
                    db_d    = data_q;
                end else begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    cs_d    = 1'b1;
                    rs_d    = 1'b1;
                end
            end

            S_DONE: begin
                state_d = S_REC;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 8'd0;
            is_reg_q <= 1'b0;
            phase_q  <= 1'b0;
            data_q   <= 16'h0000;
            done_q   <= 1'b0;
            cs_q     <= 1'b1;
            rs_q     <= 1'b1;
            wr_q     <= 1'b1;
            db_q     <= 16'h0000;
            rst_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            is_reg_q <= is_reg_d;
            phase_q  <= phase_d;
            data_q   <= data_d;
            done_q   <= done_d;
            cs_q     <= cs_d;
            rs_q     <= rs_d;
            wr_q     <= wr_d;
            db_q     <= db_d;
            rst_q    <= 1'b1;
        end
    end

    assign oDone   = done_q;
    assign TFT_RST = rst_q;
    assign TFT_CS  = cs_q;
    assign TFT_RS  = rs_q;
    assign TFT_WR  = wr_q;
    assign TFT_RD  = 1'b1;
    assign TFT_DB  = db_q;

endmodule

// File: tb/tb_tft_funcmod.sv
// Self-checking bench for tft_funcmod: vector table plus hand-written corner sequences,
// with a scoreboard of expected panel writes checked on every WR rising edge.
module tb_tft_funcmod;

    logic        CLOCK;
    logic        RESET;
    logic [2:0]  iCall;
    logic        oDone;
    logic [7:0]  iAddr;
    logic [15:0] iData;
    logic        TFT_RST, TFT_CS, TFT_RS, TFT_WR, TFT_RD;
    logic [15:0] TFT_DB;

    tft_funcmod dut (
        .CLOCK   (CLOCK),
        .RESET   (RESET),
        .iCall   (iCall),
        .oDone   (oDone),
        .iAddr   (iAddr),
        .iData   (iData),
        .TFT_RST (TFT_RST),
        .TFT_CS  (TFT_CS),
        .TFT_RS  (TFT_RS),
        .TFT_WR  (TFT_WR),
        .TFT_RD  (TFT_RD),
        .TFT_DB  (TFT_DB)
    );

    initial CLOCK = 1'b0;
    always #5 CLOCK = ~CLOCK;

    typedef struct {
        logic        rs;
        logic [15:0] db;
    } wr_t;

    typedef struct {
        logic [2:0]  call;
        logic [7:0]  addr;
        logic [15:0] data;
        int          nwr;
        logic        rs0;
        logic [15:0] db0;
        logic        rs1;
        logic [15:0] db1;
        int          done_at;
    } vec_t;

    wr_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  done_cnt = 0;
    int  wr_count = 0;
    int  exp_cs_len = 7;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge CLOCK) cyc++;

    // Monitor: panel latches on WR rising edge, so compare the scoreboard there.
    logic wr_prev = 1'b1, cs_prev = 1'b1, done_prev = 1'b0;
    int   wr_low = 0, cs_low = 0;
    always @(negedge CLOCK) begin
        if (RESET) begin
            wr_prev   = 1'b1;
            cs_prev   = 1'b1;
            done_prev = 1'b0;
            wr_low    = 0;
            cs_low    = 0;
        end else begin
            if (!TFT_WR) wr_low++;
            if (!TFT_CS) cs_low++;
            if (!wr_prev && TFT_WR) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 32'(exp_q.size()), 32'd1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("wr_rs", {31'd0, TFT_RS}, {31'd0, e.rs});
                    check("wr_db", {16'd0, TFT_DB}, {16'd0, e.db});
                end
                check("wr_low_len", 32'(wr_low), 32'd3);
                check("cs_during_wr", {31'd0, TFT_CS}, 32'd0);
                check("rd_high", {31'd0, TFT_RD}, 32'd1);
                wr_low = 0;
                wr_count++;
            end
            if (!cs_prev && TFT_CS) begin
                check("cs_low_len", 32'(cs_low), 32'(exp_cs_len));
                cs_low = 0;
            end
            if (oDone) begin
                done_cnt++;
                check("done_single", {31'd0, done_prev}, 32'd0);
            end
            wr_prev   = TFT_WR;
            cs_prev   = TFT_CS;
            done_prev = oDone;
        end
    end

    task automatic wait_done(input string name, output int n);
        n = 0;
        while (n < 60) begin
            @(negedge CLOCK);
            if (oDone) break;
            n++;
        end
        if (!oDone) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic run_vec(input vec_t v, input string name);
        int n, d0;
        @(posedge CLOCK); #1;
        iCall = v.call; iAddr = v.addr; iData = v.data;
        exp_q.push_back('{rs: v.rs0, db: v.db0});
        if (v.nwr == 2) exp_q.push_back('{rs: v.rs1, db: v.db1});
        exp_cs_len = 7 * v.nwr;
        d0 = done_cnt;
        @(posedge CLOCK); #1;
        // Inputs after acceptance must be ignored.
        iCall = 3'b000; iAddr = ~v.addr; iData = ~v.data;
        wait_done(name, n);
        check({name, "_done_cycle"}, 32'(n), 32'(v.done_at));
        check({name, "_cs_at_done"}, {31'd0, TFT_CS}, 32'd1);
        @(posedge CLOCK); #1;
        check({name, "_done_count"}, 32'(done_cnt - d0), 32'd1);
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd0);
        @(posedge CLOCK);
    endtask

    vec_t vecs[7];
    int   n, d0, w0, t_prev, t_now;

    initial begin
        #200000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{3'b010, 8'h22, 16'h1234, 1, 1'b0, 16'h0022, 1'b0, 16'h0000, 7};
        vecs[1] = '{3'b100, 8'h11, 16'h6070, 2, 1'b0, 16'h0011, 1'b1, 16'h6070, 14};
        vecs[2] = '{3'b001, 8'h5A, 16'hABCD, 1, 1'b1, 16'hABCD, 1'b0, 16'h0000, 7};
        vecs[3] = '{3'b101, 8'h33, 16'h0F0F, 2, 1'b0, 16'h0033, 1'b1, 16'h0F0F, 14};
        vecs[4] = '{3'b011, 8'h44, 16'hBEEF, 1, 1'b0, 16'h0044, 1'b0, 16'h0000, 7};
        vecs[5] = '{3'b111, 8'hFF, 16'h8001, 2, 1'b0, 16'h00FF, 1'b1, 16'h8001, 14};
        vecs[6] = '{3'b110, 8'h00, 16'h0000, 2, 1'b0, 16'h0000, 1'b1, 16'h0000, 14};

        iCall = 3'b000; iAddr = 8'h00; iData = 16'h0000;
        RESET = 1'b0;
        #1 RESET = 1'b1;

        // Reset state
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        check("rst_cs", {31'd0, TFT_CS}, 32'd1);
        check("rst_wr", {31'd0, TFT_WR}, 32'd1);
        check("rst_rd", {31'd0, TFT_RD}, 32'd1);
        check("rst_rs", {31'd0, TFT_RS}, 32'd1);
        check("rst_db", {16'd0, TFT_DB}, 32'd0);
        check("rst_done", {31'd0, oDone}, 32'd0);
        check("rst_panel_rst", {31'd0, TFT_RST}, 32'd0);
        @(posedge CLOCK); #1 RESET = 1'b0;
        @(negedge CLOCK);
        check("rst_panel_rst_held", {31'd0, TFT_RST}, 32'd0);
        @(posedge CLOCK); #1;
        check("rst_panel_rst_release", {31'd0, TFT_RST}, 32'd1);

        for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Request changed and dropped during WRLO of the command phase.
        @(posedge CLOCK); #1;
        iCall = 3'b101; iAddr = 8'h77; iData = 16'h1357;
        exp_q.push_back('{rs: 1'b0, db: 16'h0077});
        exp_q.push_back('{rs: 1'b1, db: 16'h1357});
        exp_cs_len = 14;
        d0 = done_cnt;
        @(posedge CLOCK);
        n = 0;
        do begin @(negedge CLOCK); n++; end while (TFT_WR && n < 20);
        check("ign_wr_low_seen", {31'd0, TFT_WR}, 32'd0);
        iCall = 3'b000; iAddr = 8'h00; iData = 16'hDEAD;
        wait_done("ign", n);
        @(posedge CLOCK); #1;
        check("ign_done_count", 32'(done_cnt - d0), 32'd1);
        check("ign_sb_empty", 32'(exp_q.size()), 32'd0);

        // Data stream: caller drops on oDone and re-asserts after REC.
        exp_cs_len = 7;
        w0 = wr_count;
        d0 = done_cnt;
        t_prev = 0;
        @(posedge CLOCK); #1;
        iCall = 3'b001; iData = 16'hFFFF;
        for (int i = 0; i < 240; i++) begin
            exp_q.push_back('{rs: 1'b1, db: 16'hFFFF});
            wait_done("stream", n);
            t_now = cyc;
            if (i > 0) check("stream_spacing", 32'(t_now - t_prev), 32'd9);
            t_prev = t_now;
            iCall = 3'b000;
            @(posedge CLOCK); #1;
            if (i < 239) iCall = 3'b001;
        end
        @(posedge CLOCK); #1;
        check("stream_writes", 32'(wr_count - w0), 32'd240);
        check("stream_dones", 32'(done_cnt - d0), 32'd240);
        check("stream_sb_empty", 32'(exp_q.size()), 32'd0);

        // Reset during WRLO of a data phase.
        @(posedge CLOCK); #1;
        iCall = 3'b001; iData = 16'hA5A5;
        exp_q.push_back('{rs: 1'b1, db: 16'hA5A5});
        @(posedge CLOCK); #1;
        iCall = 3'b000;
        n = 0;
        do begin @(negedge CLOCK); n++; end while (TFT_WR && n < 20);
        check("mid_wr_low_seen", {31'd0, TFT_WR}, 32'd0);
        d0 = done_cnt;
        #2 RESET = 1'b1;
        #1;
        check("mid_async_wr", {31'd0, TFT_WR}, 32'd1);
        check("mid_async_cs", {31'd0, TFT_CS}, 32'd1);
        check("mid_async_db", {16'd0, TFT_DB}, 32'd0);
        check("mid_async_panel_rst", {31'd0, TFT_RST}, 32'd0);
        exp_q.delete();
        repeat (2) @(posedge CLOCK);
        #1 RESET = 1'b0;
        repeat (12) @(negedge CLOCK);
        check("mid_no_done", 32'(done_cnt - d0), 32'd0);

        run_vec('{3'b010, 8'h2C, 16'h0000, 1, 1'b0, 16'h002C, 1'b0, 16'h0000, 7}, "after_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tft_funcmod.md
# tft_funcmod

Physical write-bus driver for the 16-bit 8080-style TFT panel interface. Sits directly downstream of the TFT control/sequencing stage. Accepts one-hot write requests (register write, command-only, data-only) together with an 8-bit register index and a 16-bit word. Generates the panel strobes `CS`, `RS`, `WR` and `RD` with parameterised setup, low and high times, and returns a one-cycle done pulse per request.

## Interface
Parameters:
- `T_SETUP`, default 1: cycles `CS`/`RS`/`DB` are valid before `WR` falls. Range 1..255.
- `T_WRL`, default 3: cycles `WR` is held low. Range 1..255.
- `T_WRH`, default 3: cycles `WR` is held high with `DB` still held, after `WR` rises. Range 1..255.

Ports:
- `CLOCK`, in, 1: single system clock; everything is on its rising edge.
- `RESET`, in, 1: asynchronous, active-high reset.
- `iCall`, in, 3: request, one-hot.
  - [2] = register write: command phase, then data phase.
  - [1] = command-only write.
  - [0] = data-only write.
- `oDone`, out, 1: one-cycle pulse when the request completes.
- `iAddr`, in, 8: register index, used for the command phase.
- `iData`, in, 16: data word, used for the data phase.
- `TFT_RST`, out, 1: panel reset, active-low.
- `TFT_CS`, out, 1: chip select, active-low.
- `TFT_RS`, out, 1: register select; 0 = command, 1 = data.
- `TFT_WR`, out, 1: write strobe, active-low; the panel latches on the rising edge.
- `TFT_RD`, out, 1: read strobe, active-low; held at 1 (this block is write-only).
- `TFT_DB`, out, 16: panel data bus.

## Operation
- All outputs are registered. States: IDLE, SETUP, WRLO, WRHI, DONE, REC.
- A phase flag selects command or data. An 8-bit down-counter times each state.

**IDLE**
- Sample `iCall`. Priority is [2] > [1] > [0].
- If no bit is set, stay in IDLE.
- On a request, latch `iAddr`/`iData`, drive `CS`=0 and set `RS` and `DB` for the first phase. Go to SETUP.
- First phase: command for [2] and [1], data for [0].
- Command phase: `RS`=0, `DB`={8'h00, `iAddr`}.
- Data phase: `RS`=1, `DB`=`iData`, taken from the value latched at request time.

**Phase sequence**
- SETUP: `WR`=1 for `T_SETUP` cycles, then go to WRLO.
- WRLO: `WR`=0 for `T_WRL` cycles, then go to WRHI.
- WRHI: `WR`=1 for `T_WRH` cycles, with `DB`/`RS` unchanged.
- End of WRHI:
  - If a data phase is still pending ([2] after its command phase), switch `RS`/`DB` to the data phase and go to SETUP. `CS` stays 0 across both phases.
  - Otherwise go to DONE.

**DONE**
- `oDone`=1, `CS`=1, `RS`=1. Go to REC.

**REC**
- `oDone`=0. Go to IDLE.
- This recovery cycle guarantees that the upstream call, dropped in response to `oDone`, is already low when IDLE samples again.

**Request handling**
- `iCall`, `iAddr` and `iData` changes after the request is latched are ignored.
- A request dropped mid-transaction still completes and still pulses `oDone`.
- Requests held high continuously, with the caller re-asserting after REC, run back-to-back. There are no extra idle cycles beyond REC.

**Reset**
- `RESET` asserted at any time, including mid-strobe, immediately forces all of the following with no done pulse:
  - state IDLE, counters 0;
  - `oDone`=0, `TFT_CS`=1, `TFT_WR`=1, `TFT_RD`=1, `TFT_RS`=1, `TFT_DB`=16'h0000;
  - `TFT_RST`=0.
- `TFT_RST` goes to 1 on the first clock edge after `RESET` deasserts.

## Timing
- Phase length P = `T_SETUP`+`T_WRL`+`T_WRH` (default 7). Edge e0 is the IDLE edge that samples the request.
- Single-phase request ([1] or [0]):
  - Phase occupies cycles e0..e0+P-1.
  - `oDone`=1 during cycle e0+P.
  - REC at e0+P+1; IDLE sampling resumes at edge e0+P+2.
- Register write ([2]):
  - Command phase is e0..e0+P-1; data phase is e0+P..e0+2P-1.
  - `oDone` at e0+2P.
- `WR` falling edge occurs `T_SETUP` cycles after `CS` falls. `WR` rising edge occurs `T_WRL` cycles later.
- `DB` and `RS` are stable from SETUP entry until WRHI exit.
- Minimum back-to-back throughput: one single-phase request per P+2 cycles.

## Test plan
- **Reset:** assert `RESET` for 3 cycles → `CS`=`WR`=`RD`=`RS`=1, `DB`=0, `oDone`=0, `TFT_RST`=0. After release, `TFT_RST`=1 at the next edge.
- **Command-only:** `iCall`=3'b010, `iAddr`=8'h22 → `RS`=0, `DB`=16'h0022, `WR` low exactly 3 cycles, `oDone` one cycle at e0+7, `CS` high at e0+7.
- **Register write:** `iCall`=3'b100, `iAddr`=8'h11, `iData`=16'h6070 → two `WR` pulses. First pulse has `RS`=0, `DB`=0x0011; second has `RS`=1, `DB`=0x6070. `CS` is low continuously for 14 cycles. `oDone` at e0+14.
- **Data stream:** upstream model writes `iData`=16'hFFFF with `iCall`=3'b001, re-asserting each time after `oDone`, 240 times → 240 `WR` pulses, each with `RS`=1 and `DB`=0xFFFF. Spacing is 9 cycles, no missed or duplicated `oDone`.
- **Priority/ignore:** `iCall`=3'b101 → behaves as register write. Changing `iData` and dropping `iCall` during WRLO → the original data is written and `oDone` is still pulsed.
- **Reset mid-operation:** `RESET` asserted during WRLO of a data phase → `WR`/`CS` return to 1 asynchronously (before the next clock edge), no `oDone`. A new request after release completes normally.
